ctr_prio_arb: RTL and testbench

Involuntary counter-increment priority controller for the counter-cell/crosspoint-control area. It latches asynchronous-origin increment requests from up to NCELLS counter cells (plus, minus or shift type). At each end-of-memory-cycle strobe it selects the highest-priority pending request and hands one increment order (PINC/MINC/DINC/PCDU/MCDU/SHINC plus counter address) to the instruction sequencer. It then holds off until the sequencer acknowledges completion.

---
 rtl/ctr_pkg.sv | 45 ++++
 rtl/ctr_prio_enc.sv | 26 ++
 rtl/ctr_prio_arb.sv | 154 +++++++++++++++
 tb/tb_ctr_prio_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// Shared definitions for the counter-increment priority controller.
//   - ctr_state_e : arbiter FSM states
//   - TYPE_*      : one-hot increment-type codes (bit order PINC..SHINC)
//   - CTR_BASE    : erasable address of counter cell 0
//   - DEF_*_MASK  : default cell-type masks for the 20-cell configuration
//   - ctr_type()  : maps a winning cell/direction to its increment type
package ctr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StWait
    } ctr_state_e;

    localparam logic [5:0] TYPE_PINC  = 6'b000001;
    localparam logic [5:0] TYPE_MINC  = 6'b000010;
    localparam logic [5:0] TYPE_PCDU  = 6'b000100;
    localparam logic [5:0] TYPE_MCDU  = 6'b001000;
    localparam logic [5:0] TYPE_DINC  = 6'b010000;
    localparam logic [5:0] TYPE_SHINC = 6'b100000;

    localparam logic [5:0] CTR_BASE = 6'o24;

    localparam logic [19:0] DEF_CDU_MASK   = 20'h0001E;
    localparam logic [19:0] DEF_DINC_MASK  = 20'h00E00;
    localparam logic [19:0] DEF_SHIFT_MASK = 20'h30000;

    // Shift and DINC cells only ever have a plus flag pending, so direction
    // matters only for CDU and ordinary cells.
    function automatic logic [5:0] ctr_type(input logic plus, input logic cdu,
                                            input logic dinc, input logic shift);
        logic [5:0] t;
        if (shift) begin
            t = TYPE_SHINC;
        end else if (dinc) begin
            t = TYPE_DINC;
        end else if (cdu) begin
            t = plus ? TYPE_PCDU : TYPE_MCDU;
        end else begin
            t = plus ? TYPE_PINC : TYPE_MINC;
        end
        return t;
    endfunction

endpackage

// File: rtl/ctr_prio_enc.sv
// Lowest-index-first priority encoder.
//   req   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when nothing is set)
//   found : any bit of req is set
module ctr_prio_enc #(
    parameter int unsigned NCELLS = 20,
    parameter int unsigned IDXW   = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic [NCELLS-1:0] req,
    output logic [IDXW-1:0]   idx,
    output logic              found
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = int'(NCELLS) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/ctr_prio_arb.sv
// Involuntary counter-increment priority controller.
// Latches plus/minus increment requests from NCELLS counter cells and, at
// each T12 strobe while idle, grants the lowest-index pending request as one
// increment order to the sequencer, then waits for CTRDN.
//   CLOCK, rst        : clock, async active-high reset
//   GOJAM             : sync restart, clears flags, OVFL and FSM
//   T12, INKL         : selection strobe and its inhibit
//   CTRDN             : sequencer completion acknowledge
//   PREQ, MREQ        : per-cell plus/minus request pulses
//   CTROR             : one-clock grant pulse
//   CADDR, PINC..SHINC: counter address and one-hot type, held through WAIT
//   BUSY, OVFL        : grant/wait in progress; sticky lost-request flag
module ctr_prio_arb import ctr_pkg::*; #(
    parameter int unsigned       NCELLS     = 20,
    parameter logic [NCELLS-1:0] CDU_MASK   = NCELLS'(DEF_CDU_MASK),
    parameter logic [NCELLS-1:0] DINC_MASK  = NCELLS'(DEF_DINC_MASK),
    parameter logic [NCELLS-1:0] SHIFT_MASK = NCELLS'(DEF_SHIFT_MASK)
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              GOJAM,
    input  logic              T12,
    input  logic              INKL,
    input  logic              CTRDN,
    input  logic [NCELLS-1:0] PREQ,
    input  logic [NCELLS-1:0] MREQ,
    output logic              CTROR,
    output logic [5:0]        CADDR,
    output logic              PINC,
    output logic              MINC,
    output logic              PCDU,
    output logic              MCDU,
    output logic              DINC,
    output logic              SHINC,
    output logic              BUSY,
    output logic              OVFL
);

    localparam int unsigned IdxW = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    ctr_state_e        state_q, state_d;
    logic [NCELLS-1:0] ppend_q, ppend_d;
    logic [NCELLS-1:0] mpend_q, mpend_d;
    logic [5:0]        caddr_q, caddr_d;
    logic [5:0]        type_q, type_d;
    logic              ovfl_q, ovfl_d;

    logic [NCELLS-1:0] mreq_eff;
    logic [NCELLS-1:0] cancel;
    logic [NCELLS-1:0] cand;
    logic [NCELLS-1:0] win_sel;
    logic [NCELLS-1:0] win_oh;
    logic [NCELLS-1:0] pclr;
    logic [NCELLS-1:0] mclr;
    logic [IdxW-1:0]   win_idx;
    logic              found;
    logic              grant;
    logic              win_plus;

    // Minus requests to DINC and shift cells have no meaning; drop them.
    assign mreq_eff = MREQ & ~(DINC_MASK | SHIFT_MASK);

    // A cell with both directions pending nets to zero: it is cleared and
    // never offered to the encoder.
    assign cancel = ppend_q & mpend_q;
    assign cand   = ppend_q ^ mpend_q;

    ctr_prio_enc #(
        .NCELLS (NCELLS),
        .IDXW   (IdxW)
    ) u_enc (
        .req   (cand),
        .idx   (win_idx),
        .found (found)
    );

    assign grant    = (state_q == StIdle) && T12 && !INKL && found;
    assign win_sel  = NCELLS'(1) << win_idx;
    assign win_oh   = grant ? win_sel : '0;
    assign win_plus = |(win_sel & ppend_q);

    assign pclr = cancel | (win_oh & ppend_q);
    assign mclr = cancel | (win_oh & mpend_q);

    always_comb begin
        state_d = state_q;
        caddr_d = caddr_q;
        type_d  = type_q;
        // A request landing on a flag that is being cleared this edge wins.
        ppend_d = (ppend_q & ~pclr) | PREQ;
        mpend_d = (mpend_q & ~mclr) | mreq_eff;
        ovfl_d  = ovfl_q | (|(PREQ & ppend_q & ~pclr)) | (|(mreq_eff & mpend_q & ~mclr));

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StGrant;
                    caddr_d = CTR_BASE + 6'(win_idx);
                    type_d  = ctr_type(win_plus, |(win_sel & CDU_MASK),
                                       |(win_sel & DINC_MASK), |(win_sel & SHIFT_MASK));
                end
            end
            StGrant: state_d = StWait;
            StWait: begin
                if (CTRDN) begin
                    state_d = StIdle;
                    caddr_d = '0;
                    type_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (GOJAM) begin
            state_d = StIdle;
            ppend_d = '0;
            mpend_d = '0;
            caddr_d = '0;
            type_d  = '0;
            ovfl_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ppend_q <= '0;
            mpend_q <= '0;
            caddr_q <= '0;
            type_q  <= '0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ppend_q <= ppend_d;
            mpend_q <= mpend_d;
            caddr_q <= caddr_d;
            type_q  <= type_d;
            ovfl_q  <= ovfl_d;
        end
    end

    // All outputs come straight from registers, so reset removes them cleanly.
    assign CTROR = (state_q == StGrant);
    assign BUSY  = (state_q != StIdle);
    assign CADDR = caddr_q;
    assign OVFL  = ovfl_q;
    assign PINC  = type_q[0];
    assign MINC  = type_q[1];
    assign PCDU  = type_q[2];
    assign MCDU  = type_q[3];
    assign DINC  = type_q[4];
    assign SHINC = type_q[5];

endmodule

// File: tb/tb_ctr_prio_arb.sv
// Directed bench for ctr_prio_arb with default 20-cell masks.
module tb_ctr_prio_arb;

    localparam int N = 20;

    // Type vector as seen by the bench: {SHINC,DINC,MCDU,PCDU,MINC,PINC}
    localparam logic [5:0] T_NONE  = 6'b000000;
    localparam logic [5:0] T_PINC  = 6'b000001;
    localparam logic [5:0] T_MINC  = 6'b000010;
    localparam logic [5:0] T_PCDU  = 6'b000100;
    localparam logic [5:0] T_MCDU  = 6'b001000;
    localparam logic [5:0] T_DINC  = 6'b010000;
    localparam logic [5:0] T_SHINC = 6'b100000;

    logic         CLOCK = 1'b0;
    logic         rst   = 1'b1;
    logic         GOJAM = 1'b0;
    logic         T12   = 1'b0;
    logic         INKL  = 1'b0;
    logic         CTRDN = 1'b0;
    logic [N-1:0] PREQ  = '0;
    logic [N-1:0] MREQ  = '0;
    logic         CTROR, PINC, MINC, PCDU, MCDU, DINC, SHINC, BUSY, OVFL;
    logic [5:0]   CADDR;
    logic [5:0]   typ;

    int n_total = 0;
    int n_bad   = 0;

    assign typ = {SHINC, DINC, MCDU, PCDU, MINC, PINC};

    ctr_prio_arb dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .GOJAM (GOJAM),
        .T12   (T12),
        .INKL  (INKL),
        .CTRDN (CTRDN),
        .PREQ  (PREQ),
        .MREQ  (MREQ),
        .CTROR (CTROR),
        .CADDR (CADDR),
        .PINC  (PINC),
        .MINC  (MINC),
        .PCDU  (PCDU),
        .MCDU  (MCDU),
        .DINC  (DINC),
        .SHINC (SHINC),
        .BUSY  (BUSY),
        .OVFL  (OVFL)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic expect_out(input string tag, input logic ctror, input logic busy,
                              input logic [5:0] caddr, input logic [5:0] t);
        check({tag, "_ctror"}, 32'(CTROR), 32'(ctror));
        check({tag, "_busy"},  32'(BUSY),  32'(busy));
        check({tag, "_caddr"}, 32'(CADDR), 32'(caddr));
        check({tag, "_type"},  32'(typ),   32'(t));
    endtask

    task automatic pulse_preq(input int i);
        PREQ[i] = 1'b1;
        tick();
        PREQ = '0;
    endtask

    task automatic pulse_mreq(input int i);
        MREQ[i] = 1'b1;
        tick();
        MREQ = '0;
    endtask

    task automatic pulse_t12();
        T12 = 1'b1;
        tick();
        T12 = 1'b0;
    endtask

    task automatic ack();
        CTRDN = 1'b1;
        tick();
        CTRDN = 1'b0;
    endtask

    task automatic pulse_gojam();
        GOJAM = 1'b1;
        tick();
        GOJAM = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        expect_out("reset", 1'b0, 1'b0, 6'o00, T_NONE);
        check("reset_ovfl", 32'(OVFL), 32'd0);
        rst = 1'b0;
        tick();

        // Single plus request on an ordinary cell.
        pulse_preq(5);
        pulse_t12();
        expect_out("c5_grant", 1'b1, 1'b1, 6'o31, T_PINC);
        tick();
        expect_out("c5_wait", 1'b0, 1'b1, 6'o31, T_PINC);
        ack();
        expect_out("c5_done", 1'b0, 1'b0, 6'o00, T_NONE);

        // New request on the same edge the flag is granted: stays set, no OVFL.
        pulse_preq(5);
        PREQ[5] = 1'b1;
        T12 = 1'b1;
        tick();
        PREQ = '0;
        T12 = 1'b0;
        expect_out("c5_again", 1'b1, 1'b1, 6'o31, T_PINC);
        tick();
        ack();
        check("setclr_ovfl", 32'(OVFL), 32'd0);
        pulse_t12();
        expect_out("c5_kept", 1'b1, 1'b1, 6'o31, T_PINC);
        tick();
        ack();

        // Priority: CDU cell 2 before DINC cell 9.
        pulse_preq(2);
        pulse_preq(9);
        pulse_t12();
        expect_out("c2_grant", 1'b1, 1'b1, 6'o26, T_PCDU);
        tick();
        ack();
        pulse_t12();
        expect_out("c9_grant", 1'b1, 1'b1, 6'o35, T_DINC);
        tick();
        ack();

        // Plus and minus on the same cell cancel.
        pulse_preq(7);
        pulse_mreq(7);
        pulse_t12();
        expect_out("cancel_t12", 1'b0, 1'b0, 6'o00, T_NONE);
        check("cancel_ovfl", 32'(OVFL), 32'd0);
        pulse_t12();
        expect_out("cancel_t12b", 1'b0, 1'b0, 6'o00, T_NONE);

        // Minus on ordinary and CDU cells; minus on a DINC cell is dropped.
        pulse_mreq(12);
        pulse_mreq(10);
        pulse_mreq(4);
        pulse_t12();
        expect_out("c4_minus", 1'b1, 1'b1, 6'o30, T_MCDU);
        tick();
        ack();
        pulse_t12();
        expect_out("c12_minus", 1'b1, 1'b1, 6'o40, T_MINC);
        tick();
        ack();
        pulse_t12();
        expect_out("c10_dropped", 1'b0, 1'b0, 6'o00, T_NONE);
        check("dinc_minus_ovfl", 32'(OVFL), 32'd0);

        // Double request on a shift cell: overflow, single SHINC grant.
        pulse_preq(16);
        pulse_preq(16);
        check("ovfl_set", 32'(OVFL), 32'd1);
        pulse_t12();
        expect_out("c16_grant", 1'b1, 1'b1, 6'o44, T_SHINC);
        tick();
        ack();
        pulse_t12();
        expect_out("c16_once", 1'b0, 1'b0, 6'o00, T_NONE);
        check("ovfl_sticky", 32'(OVFL), 32'd1);
        pulse_gojam();
        check("ovfl_gojam", 32'(OVFL), 32'd0);

        // INKL suppresses T12.
        pulse_preq(0);
        INKL = 1'b1;
        pulse_t12();
        INKL = 1'b0;
        expect_out("inkl", 1'b0, 1'b0, 6'o00, T_NONE);
        pulse_t12();
        expect_out("c0_grant", 1'b1, 1'b1, 6'o24, T_PINC);
        tick();
        // T12 in WAIT is ignored; the pending request waits.
        pulse_preq(3);
        pulse_t12();
        expect_out("t12_wait", 1'b0, 1'b1, 6'o24, T_PINC);
        ack();
        // Request on the T12 clock is not a candidate there.
        PREQ[1] = 1'b1;
        T12 = 1'b1;
        tick();
        PREQ = '0;
        T12 = 1'b0;
        expect_out("c3_grant", 1'b1, 1'b1, 6'o27, T_PCDU);
        tick();
        ack();
        pulse_t12();
        expect_out("c1_grant", 1'b1, 1'b1, 6'o25, T_PCDU);
        tick();
        ack();

        // Asynchronous reset while in WAIT.
        pulse_preq(8);
        pulse_t12();
        tick();
        expect_out("c8_wait", 1'b0, 1'b1, 6'o34, T_NONE | 6'b000001);
        #1 rst = 1'b1;
        #1 expect_out("rst_wait", 1'b0, 1'b0, 6'o00, T_NONE);
        tick();
        rst = 1'b0;
        tick();

        // GOJAM with flags pending and OVFL set.
        pulse_preq(13);
        pulse_preq(13);
        check("ovfl_c13", 32'(OVFL), 32'd1);
        pulse_gojam();
        check("gojam_ovfl", 32'(OVFL), 32'd0);
        expect_out("gojam_idle", 1'b0, 1'b0, 6'o00, T_NONE);
        pulse_t12();
        expect_out("gojam_noflag", 1'b0, 1'b0, 6'o00, T_NONE);

        // GOJAM during WAIT.
        pulse_preq(15);
        pulse_preq(18);
        pulse_t12();
        tick();
        expect_out("c15_wait", 1'b0, 1'b1, 6'o43, T_PINC);
        pulse_gojam();
        expect_out("gojam_wait", 1'b0, 1'b0, 6'o00, T_NONE);
        pulse_t12();
        expect_out("gojam_wait_t12", 1'b0, 1'b0, 6'o00, T_NONE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
